// File: rtl/shift_reg_pkg.sv
// Shared types and the next-state data function for the universal shift register.
// Register values travel through the function zero-extended to MAX_W bits.
package shift_reg_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    LOAD  = 3'd1,
    SHL   = 3'd2,
    SHR   = 3'd3,
    ROL   = 3'd4,
    ROR   = 3'd5,
    CLEAR = 3'd6,
    RSVD  = 3'd7
  } mode_e;

  // w is the live register width; bits at or above w are returned as zero.
  function automatic logic [MAX_W-1:0] next_data(
    input mode_e            mode,
    input logic [MAX_W-1:0] dout,
    input logic [MAX_W-1:0] din,
    input logic             sl,
    input logic             sr,
    input int unsigned      w
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] msb_bit;
    logic [MAX_W-1:0] res;
    mask    = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    msb_bit = MAX_W'(1) << (w - 1);
    res     = dout;
    case (mode)
      LOAD:    res = din;
      SHL:     res = (dout << 1) | MAX_W'(sl);
      SHR:     res = (dout >> 1) | (sr ? msb_bit : '0);
      ROL:     res = (dout << 1) | MAX_W'(dout[w-1]);
      ROR:     res = (dout >> 1) | (dout[0] ? msb_bit : '0);
      CLEAR:   res = '0;
      default: res = dout;
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// Mod-WIDTH shift counter; pulses wrap for one cycle each time WIDTH shifts complete.
// clr discards a partial count without producing a pulse.
module shift_frame_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (en) begin
      if (clr) begin
        count_d = '0;
      end else if (inc) begin
        if (count_q == CNT_W'(WIDTH - 1)) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/shift_reg_universal.sv
// Universal WIDTH-bit shift register: hold, load, shift/rotate left/right, clear,
// with a frame counter that flags every WIDTH consecutive shift/rotate operations.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             din_serie_l,
  input  logic             din_serie_r,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] bit_count,
  output logic             frame_done
);

  mode_e            mode_sel;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [MAX_W-1:0] next_full;
  logic             cnt_inc;
  logic             cnt_clr;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    next_full = next_data(mode_sel, MAX_W'(dout_q), MAX_W'(din),
                          din_serie_l, din_serie_r, WIDTH);
    dout_d    = dout_q;
    if (en) begin
      dout_d = next_full[WIDTH-1:0];
    end
  end

  // Bits above WIDTH are always zero coming out of next_data.
  if (WIDTH < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = |next_full[MAX_W-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  always_comb begin
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (mode_sel)
      SHL, SHR, ROL, ROR: cnt_inc = 1'b1;
      LOAD, CLEAR:        cnt_clr = 1'b1;
      default:            ;
    endcase
  end

  shift_frame_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_frame_counter (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .count (bit_count),
    .wrap  (frame_done)
  );

  assign dout     = dout_q;
  assign sout_msb = dout_q[WIDTH-1];
  assign sout_lsb = dout_q[0];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed and randomized bench for shift_reg_universal (WIDTH=4) against an
// arithmetic reference model of the register value and the shift count.
module tb_shift_reg_universal;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic         din_serie_l = 1'b0;
  logic         din_serie_r = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         sout_msb;
  logic         sout_lsb;
  logic [2:0]   bit_count;
  logic         frame_done;

  int errors = 0;
  int checks = 0;

  int m_val = 0;
  int m_cnt = 0;
  int m_fd  = 0;

  shift_reg_universal #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .mode        (mode),
    .din_serie_l (din_serie_l),
    .din_serie_r (din_serie_r),
    .din         (din),
    .dout        (dout),
    .sout_msb    (sout_msb),
    .sout_lsb    (sout_lsb),
    .bit_count   (bit_count),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: value as an integer in [0, 2^W), count as shifts since last restart.
  task automatic model_update(input logic r, input logic e, input int md,
                              input int l, input int rr, input int dd);
    if (r) begin
      m_val = 0; m_cnt = 0; m_fd = 0;
    end else if (!e) begin
      m_fd = 0;
    end else begin
      m_fd = 0;
      case (md)
        1: begin m_val = dd; m_cnt = 0; end
        6: begin m_val = 0;  m_cnt = 0; end
        2, 3, 4, 5: begin
          if (md == 2) m_val = (m_val * 2 + l) % M;
          if (md == 3) m_val = m_val / 2 + rr * (M / 2);
          if (md == 4) m_val = (m_val * 2) % M + m_val / (M / 2);
          if (md == 5) m_val = m_val / 2 + (m_val % 2) * (M / 2);
          m_cnt = m_cnt + 1;
          if (m_cnt == W) begin
            m_cnt = 0;
            m_fd  = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] md,
                      input logic l, input logic rr, input logic [W-1:0] dd);
    reset = r; en = e; mode = md; din_serie_l = l; din_serie_r = rr; din = dd;
    @(posedge clk);
    model_update(r, e, int'(md), int'(l), int'(rr), int'(dd));
    #1;
    check("dout", 32'(dout), 32'(m_val));
    check("bit_count", 32'(bit_count), 32'(m_cnt));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("sout_msb", 32'(sout_msb), 32'((m_val >> (W - 1)) & 1));
    check("sout_lsb", 32'(sout_lsb), 32'(m_val & 1));
  endtask

  initial begin
    int fd_seen;

    // Reset with LOAD pending must not load.
    step(1, 1, 3'd1, 0, 0, 4'hF);
    step(1, 1, 3'd1, 0, 0, 4'hF);
    check("reset_dout", 32'(dout), 32'h0);

    // LOAD then four rotates left.
    step(0, 1, 3'd1, 0, 0, 4'b1011);
    step(0, 1, 3'd4, 0, 0, 4'h0);
    check("rol1_dout", 32'(dout), 32'b0111);
    step(0, 1, 3'd4, 0, 0, 4'h0);
    step(0, 1, 3'd4, 0, 0, 4'h0);
    check("rol3_fd", 32'(frame_done), 32'd0);
    step(0, 1, 3'd4, 0, 0, 4'h0);
    check("rol4_dout", 32'(dout), 32'b1011);
    check("rol4_fd", 32'(frame_done), 32'd1);
    step(0, 1, 3'd0, 0, 0, 4'h0);
    check("hold_fd_low", 32'(frame_done), 32'd0);

    // Serial in left, then right.
    step(0, 1, 3'd1, 0, 0, 4'h0);
    step(0, 1, 3'd2, 1, 1, 4'h0);
    step(0, 1, 3'd2, 0, 1, 4'h0);
    step(0, 1, 3'd2, 1, 1, 4'h0);
    step(0, 1, 3'd2, 1, 0, 4'h0);
    check("shl4_dout", 32'(dout), 32'b1011);
    check("shl4_fd", 32'(frame_done), 32'd1);
    step(0, 1, 3'd3, 1, 0, 4'h0);
    step(0, 1, 3'd3, 1, 0, 4'h0);
    check("shr2_dout", 32'(dout), 32'b0010);
    check("shr2_cnt", 32'(bit_count), 32'd2);

    // Reload mid-frame discards the count.
    step(0, 1, 3'd1, 0, 0, 4'h9);
    step(0, 1, 3'd5, 0, 0, 4'h0);
    step(0, 1, 3'd5, 0, 0, 4'h0);
    step(0, 1, 3'd1, 0, 0, 4'h6);
    step(0, 1, 3'd5, 0, 0, 4'h0);
    step(0, 1, 3'd5, 0, 0, 4'h0);
    step(0, 1, 3'd5, 0, 0, 4'h0);
    check("ror_dout", 32'(dout), 32'b1100);
    check("ror_cnt", 32'(bit_count), 32'd3);
    check("ror_no_fd", 32'(frame_done), 32'd0);

    // Enable low freezes state mid-frame.
    step(0, 1, 3'd1, 0, 0, 4'h0);
    step(0, 1, 3'd2, 1, 0, 4'h0);
    step(0, 1, 3'd2, 1, 0, 4'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 3'd2, 0, 0, 4'h0);
    check("frozen_dout", 32'(dout), 32'b0011);
    check("frozen_cnt", 32'(bit_count), 32'd2);
    step(0, 1, 3'd2, 0, 0, 4'h0);
    step(0, 1, 3'd2, 1, 0, 4'h0);
    check("resume_fd", 32'(frame_done), 32'd1);

    // Reset mid-frame, then a fresh frame, then reserved mode.
    step(0, 1, 3'd2, 1, 0, 4'h0);
    step(0, 1, 3'd2, 1, 0, 4'h0);
    step(1, 1, 3'd2, 1, 0, 4'h0);
    check("midreset_cnt", 32'(bit_count), 32'd0);
    fd_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 3'd2, 1, 0, 4'h0);
      fd_seen += int'(frame_done);
    end
    check("one_fd_after_reset", 32'(fd_seen), 32'd1);
    step(0, 1, 3'd7, 0, 1, 4'h5);
    check("rsvd_dout", 32'(dout), 32'hF);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
           4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
